// File: rtl/adc128s_spi_model.sv
`default_nettype none
// ============================================================================
//  Module   : adc128s_spi_model
//  Purpose  : Model of an 8-channel, 12-bit SPI A2D converter. It supplies the
//             left load cell, right load cell and battery readings to the
//             Segway A2D interface. Each 16-bit transaction shifts a channel
//             command in and returns the conversion of the channel commanded
//             in the previous completed transaction.
//  Ports    : clk      - system clock (the only clock)
//             rst_n    - asynchronous active-low reset
//             SS_n     - SPI slave select, active low
//             SCLK     - SPI serial clock, idles high
//             MOSI     - command bits from master, MSB first
//             MISO     - result bits to master, MSB first, high-Z when idle
//             lft_ld   - left load cell value (12 bits)
//             rght_ld  - right load cell value (12 bits)
//             batt     - battery voltage value (12 bits)
//  Revision : 1.0 - initial release
// ============================================================================
module adc128s_spi_model #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic [11:0] batt
);

    localparam logic [4:0] c_FULL_CNT = 5'd16;

    // Synchronizer chains: index 0 is the first flop. SCLK and SS_n carry a
    // third stage so edges are detected between stages 1 and 2.
    logic [2:0]  r_sclk_sync;
    logic [2:0]  r_ss_sync;
    logic [1:0]  r_mosi_sync;

    logic [15:0] r_tx_shft;
    logic [15:0] r_rx_shft;
    logic [4:0]  r_bit_cnt;
    logic [2:0]  r_pend_ch;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_ss_active;
    logic [11:0] w_snap_val;
    logic        w_unused_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b111;
            r_ss_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_ss_sync   <= {r_ss_sync[1:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
    assign w_ss_active = ~r_ss_sync[1];

    // Value loaded at the start of a transaction, selected by the channel
    // commanded in the previous completed transaction.
    always_comb begin
        w_snap_val = 12'h000;
        if (r_pend_ch == LFT_CH) begin
            w_snap_val = lft_ld;
        end else if (r_pend_ch == RGHT_CH) begin
            w_snap_val = rght_ld;
        end else if (r_pend_ch == BATT_CH) begin
            w_snap_val = batt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shft <= 16'h0000;
            r_rx_shft <= 16'h0000;
            r_bit_cnt <= 5'd0;
            r_pend_ch <= 3'd0;
        end else if (w_ss_fall) begin
            // Load takes precedence over any SCLK edge seen in the same cycle.
            r_tx_shft <= {4'h0, w_snap_val};
            r_rx_shft <= 16'h0000;
            r_bit_cnt <= 5'd0;
        end else if (w_ss_active) begin
            if (w_sclk_rise) begin
                r_rx_shft <= {r_rx_shft[14:0], r_mosi_sync[1]};
                if (r_bit_cnt != c_FULL_CNT) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
            // The leading fall (before any rise) must not shift, otherwise
            // the MSB already on MISO would be lost before the master samples.
            if (w_sclk_fall && (r_bit_cnt != 5'd0)) begin
                r_tx_shft <= {r_tx_shft[14:0], 1'b0};
            end
        end else if (w_ss_rise) begin
            // Only a complete transaction updates the pending channel.
            if (r_bit_cnt == c_FULL_CNT) begin
                r_pend_ch <= r_rx_shft[13:11];
            end
        end
    end

    // Bit 15 of the receive register is shifted out and never inspected.
    assign w_unused_rx = r_rx_shft[15];

    assign MISO = w_ss_active ? r_tx_shft[15] : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_adc128s_spi_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc128s_spi_model
//  Purpose  : Self-checking bench for adc128s_spi_model. An SPI master task
//             drives transactions; the expected response is pushed to a
//             scoreboard queue when a transaction starts and popped and
//             compared when the transaction completes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc128s_spi_model;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss_n  = 1'b1;
    logic        sclk  = 1'b1;
    logic        mosi  = 1'b0;
    wire         miso;
    logic [11:0] lft_ld  = 12'h000;
    logic [11:0] rght_ld = 12'h000;
    logic [11:0] batt    = 12'h000;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [2:0]  pend        = 3'd0;
    logic [15:0] sb_q[$];

    // A released MISO reads back as 1 through this pull-up.
    pullup (miso);

    always #5 clk = ~clk;

    adc128s_spi_model #(
        .LFT_CH  (3'd0),
        .RGHT_CH (3'd4),
        .BATT_CH (3'd5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (ss_n),
        .SCLK    (sclk),
        .MOSI    (mosi),
        .MISO    (miso),
        .lft_ld  (lft_ld),
        .rght_ld (rght_ld),
        .batt    (batt)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_val(input logic [2:0] ch);
        case (ch)
            3'd0:    model_val = lft_ld;
            3'd4:    model_val = rght_ld;
            3'd5:    model_val = batt;
            default: model_val = 12'h000;
        endcase
    endfunction

    // n bits of 'bits' (MSB first). If chg_at >= 0, batt becomes chg_val
    // right after rise number chg_at (0-based).
    task automatic xfer(input string tag, input logic [31:0] bits, input int n,
                        input int chg_at, input logic [11:0] chg_val);
        logic [31:0] resp;
        logic [31:0] e;
        logic [15:0] exp16;
        sb_q.push_back({4'h0, model_val(pend)});
        resp = 32'h0;
        ss_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            mosi = bits[n-1-i];
            wait_clk(8);
            resp = {resp[30:0], miso};
            sclk = 1'b1;
            wait_clk(8);
            if (i == chg_at) batt = chg_val;
        end
        wait_clk(4);
        ss_n = 1'b1;
        wait_clk(6);
        if (n >= 16) pend = bits[13:11];
        check({tag, "_idle_miso"}, {31'h0, miso}, 32'h1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'h0, 32'h1);
        end else begin
            exp16 = sb_q.pop_front();
            e = {16'h0, exp16};
            if (n <= 16) e = e >> (16 - n);
            else         e = e << (n - 16);
            check(tag, resp, e);
        end
    endtask

    initial begin
        lft_ld  = 12'h3A5;
        rght_ld = 12'h1FF;
        batt    = 12'h900;
        wait_clk(3);
        check("reset_miso", {31'h0, miso}, 32'h1);
        rst_n = 1'b1;
        wait_clk(4);
        check("post_reset_miso", {31'h0, miso}, 32'h1);

        // Default channel 0, then ch4 response
        xfer("t1_ch0_default", 32'h2000, 16, -1, 12'h0);
        xfer("t2_rght", 32'h2800, 16, -1, 12'h0);
        // Battery with mid-transaction input change
        xfer("t3_batt", 32'h2800, 16, -1, 12'h0);
        xfer("t4_batt_snap", 32'h2800, 16, 5, 12'h7FF);
        xfer("t5_batt_new", 32'h2800, 16, -1, 12'h0);
        // Unmapped channel returns zero
        xfer("t6_cmd_ch3", 32'h1800, 16, -1, 12'h0);
        xfer("t7_ch3_zero", 32'h2000, 16, -1, 12'h0);
        // Aborted ch5 command after 8 rises leaves ch4 pending
        xfer("t8_abort", 32'h0000_0028, 8, -1, 12'h0);
        xfer("t9_after_abort", 32'h0000, 16, -1, 12'h0);

        // Reset in the middle of a ch4 command
        lft_ld = 12'h5C3;
        xfer("t10_lft", 32'h2800, 16, -1, 12'h0);
        ss_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b0;
            mosi = (i == 2) ? 1'b1 : 1'b0;
            wait_clk(8);
            sclk = 1'b1;
            wait_clk(8);
        end
        rst_n = 1'b0;
        wait_clk(2);
        check("mid_reset_miso", {31'h0, miso}, 32'h1);
        ss_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        pend = 3'd0;
        xfer("t11_after_reset", 32'h2800, 16, -1, 12'h0);

        // SCLK toggling with SS_n high is ignored
        for (int i = 0; i < 16; i++) begin
            sclk = 1'b0;
            mosi = ~mosi;
            wait_clk(4);
            check("idle_toggle_miso", {31'h0, miso}, 32'h1);
            sclk = 1'b1;
            wait_clk(4);
        end
        xfer("t12_after_toggle", 32'h2000, 16, -1, 12'h0);
        xfer("t13_rght", 32'h0000, 16, -1, 12'h0);

        // Over-length transaction: last 16 bits form the command
        xfer("t14_overlen", 32'h0003_2800, 18, -1, 12'h0);
        xfer("t15_batt", 32'h0000, 16, -1, 12'h0);

        check("sb_drained", sb_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc128s_spi_model.md
Name:
adc128s_spi_model

Overview:
- Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) used in the Segway system bench.
- Presents left load cell, right load cell and battery readings to the Segway A2D interface.
- Each 16-bit SPI transaction carries a channel command in. The same transaction returns the conversion of the channel commanded in the previous transaction.

Parameters:
- LFT_CH, 3'd0, channel number returning lft_ld
- RGHT_CH, 3'd4, channel number returning rght_ld
- BATT_CH, 3'd5, channel number returning batt

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- SS_n  in  1  SPI slave select, active low
- SCLK  in  1  SPI serial clock from master; idles high
- MOSI  in  1  command data from master, MSB first
- MISO  out  1  result data to master, MSB first; high-Z while SS_n high
- lft_ld  in  12  left load cell analog value
- rght_ld  in  12  right load cell analog value
- batt  in  12  battery voltage value

Behaviour:
- Synchronization
  - SCLK, SS_n and MOSI pass through two clk flops, plus a third flop on SCLK and SS_n for edge detect.
  - sclk_rise = ff2 & ~ff3; sclk_fall = ~ff2 & ff3; ss_fall and ss_rise are defined likewise.
  - All state is updated on posedge clk only.
- SPI protocol
  - Mode: SCLK idles high; master changes MOSI on SCLK fall and samples MISO on SCLK rise.
  - Transaction length: 16 SCLK rises.
- Transaction start (ss_fall)
  - Snapshot the pending channel's input into tx_shft = {4'h0, value}.
  - Clear bit counter and rx_shft.
  - MISO = tx_shft[15] immediately.
- Channel mapping for the snapshot
  - LFT_CH → lft_ld; RGHT_CH → rght_ld; BATT_CH → batt.
  - Any other channel → 12'h000.
- While SS_n low
  - sclk_rise: rx_shft = {rx_shft[14:0], MOSI_sync}; bit counter increments, saturating at 16.
  - sclk_fall with bit counter ≥ 1: tx_shft shifts left, filling with 0.
  - sclk_fall with bit counter = 0 (the leading fall): ignored.
- Transaction end (ss_rise)
  - Bit counter = 16: pending channel ← rx_shft[13:11]. Bits [15:14] and [10:0] are don't-care.
  - Bit counter < 16 (aborted transaction): pending channel unchanged.
- Latency
  - A response always belongs to the command of the prior completed transaction.
  - Back-to-back transactions with the same command return that channel from the second one onward.
- MISO drive
  - Driven only while the synchronized SS_n is low; 1'bz otherwise.
- Input sampling
  - Input changes during a transaction do not affect the data being returned; the snapshot is taken at ss_fall only.
- Reset (asynchronous, rst_n low)
  - pending channel = 0; tx_shft = 0; rx_shft = 0; bit counter = 0.
  - Sync flops: SCLK and SS_n chains reset to 1; MOSI chain resets to 0.
  - MISO = z.
  - The first transaction after reset returns lft_ld (channel 0).
  - Reset during a transaction aborts it; the command is not latched.
- Edge cases
  - SCLK edges while SS_n high are ignored.
  - More than 16 rises in one transaction: the last 16 received bits form the command; tx shifts out zeros.
  - ss_fall and sclk_fall in the same cycle: ss_fall load wins.

Test Plan:
- Reset, then lft_ld=12'h3A5; run one transaction with cmd 16'h2000 (ch4) → master reads 16'h03A5 (ch0 default). A second transaction with cmd 16'h2800 (ch5) while rght_ld=12'h1FF → reads 16'h01FF.
- batt=12'h900; after two ch5 commands (16'h2800), change batt to 12'h7FF mid-transaction → the current read is 16'h0900 and the next read is 16'h07FF.
- Command ch3 (16'h1800), then any transaction → reads 16'h0000.
- Abort a transaction after 8 SCLK rises with cmd ch5 while the previous channel is ch4 → the next read returns rght_ld, not batt.
- Assert rst_n low mid-transaction; release and run one transaction → returns lft_ld; MISO = z whenever SS_n high.
- Toggle SCLK 16 times with SS_n high, then run a normal ch4 command → pending channel unchanged by the idle toggles; the following read returns rght_ld.
